// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared constants and FSM encodings for the codec serial slave
package codec_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int FRAME_BITS = 2 * DEF_DATA_W;

    typedef enum logic [1:0] {
        DAC_IDLE,
        DAC_SHIFT,
        DAC_DONE
    } dac_state_t;

    typedef enum logic {
        ADC_IDLE,
        ADC_SEND
    } adc_state_t;

endpackage

// File: rtl/codec_sync_edge.sv
// rtl/codec_sync_edge.sv - multi-stage synchroniser with rise/fall pulses
module codec_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/codec_serial_slave.sv
// rtl/codec_serial_slave.sv - codec-side left-justified audio port (DAC receive, ADC transmit)
module codec_serial_slave
    import codec_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                b_clk,
    input  logic                dac_lr_clk,
    input  logic                adc_lr_clk,
    input  logic                dacdat,
    output logic                adcdat,
    input  logic [2*DATA_W-1:0] adc_data_in,
    output logic                adc_load_tick,
    output logic [2*DATA_W-1:0] dac_data_out,
    output logic                dac_valid,
    output logic                frame_err
);

    localparam int NBITS = 2 * DATA_W;
    localparam int CW    = $clog2(NBITS + 1);

    logic b_level_unused, b_rise, b_fall;
    logic dac_lr_level_unused, dac_lr_rise, dac_lr_fall_unused;
    logic adc_lr_level_unused, adc_lr_rise, adc_lr_fall_unused;
    logic dacdat_s, dat_rise_unused, dat_fall_unused;

    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset(reset), .d(b_clk),
        .q(b_level_unused), .rise(b_rise), .fall(b_fall)
    );
    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dac_lr (
        .clk(clk), .reset(reset), .d(dac_lr_clk),
        .q(dac_lr_level_unused), .rise(dac_lr_rise), .fall(dac_lr_fall_unused)
    );
    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adc_lr (
        .clk(clk), .reset(reset), .d(adc_lr_clk),
        .q(adc_lr_level_unused), .rise(adc_lr_rise), .fall(adc_lr_fall_unused)
    );
    // Same depth as b_clk so dacdat_s is the value present at the detected edge.
    codec_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dacdat (
        .clk(clk), .reset(reset), .d(dacdat),
        .q(dacdat_s), .rise(dat_rise_unused), .fall(dat_fall_unused)
    );

    dac_state_t        dac_state, dac_state_n;
    logic [CW-1:0]     dac_cnt, dac_cnt_n;
    logic [NBITS-1:0]  dac_shreg, dac_shreg_n;
    logic [NBITS-1:0]  dac_data_n;
    logic              dac_valid_n, frame_err_n;

    always_comb begin
        dac_state_n = dac_state;
        dac_cnt_n   = dac_cnt;
        dac_shreg_n = dac_shreg;
        dac_data_n  = dac_data_out;
        dac_valid_n = 1'b0;
        frame_err_n = 1'b0;
        if (dac_lr_rise) begin
            // Frame start wins over a coincident bit edge; that bit becomes the MSB.
            frame_err_n = (dac_state == DAC_SHIFT);
            dac_state_n = DAC_SHIFT;
            dac_shreg_n = '0;
            dac_cnt_n   = '0;
            if (b_rise) begin
                dac_shreg_n = NBITS'(dacdat_s);
                dac_cnt_n   = CW'(1);
            end
        end else if (dac_state == DAC_SHIFT && b_rise) begin
            dac_shreg_n = {dac_shreg[NBITS-2:0], dacdat_s};
            dac_cnt_n   = dac_cnt + CW'(1);
            if (dac_cnt == CW'(NBITS - 1)) begin
                dac_data_n  = dac_shreg_n;
                dac_valid_n = 1'b1;
                dac_state_n = DAC_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_state    <= DAC_IDLE;
            dac_cnt      <= '0;
            dac_shreg    <= '0;
            dac_data_out <= '0;
            dac_valid    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            dac_state    <= dac_state_n;
            dac_cnt      <= dac_cnt_n;
            dac_shreg    <= dac_shreg_n;
            dac_data_out <= dac_data_n;
            dac_valid    <= dac_valid_n;
            frame_err    <= frame_err_n;
        end
    end

    adc_state_t        adc_state, adc_state_n;
    logic [CW-1:0]     adc_cnt, adc_cnt_n;
    logic [NBITS-1:0]  adc_shreg, adc_shreg_n;
    logic              adcdat_n, adc_tick_n;

    always_comb begin
        adc_state_n = adc_state;
        adc_cnt_n   = adc_cnt;
        adc_shreg_n = adc_shreg;
        adcdat_n    = adcdat;
        adc_tick_n  = 1'b0;
        if (adc_lr_rise) begin
            adc_state_n = ADC_SEND;
            adc_shreg_n = adc_data_in;
            adcdat_n    = adc_data_in[NBITS-1];
            adc_tick_n  = 1'b1;
            adc_cnt_n   = '0;
        end else if (adc_state == ADC_SEND && b_fall) begin
            if (adc_cnt == CW'(NBITS - 1)) begin
                adcdat_n    = 1'b0;
                adc_state_n = ADC_IDLE;
            end else begin
                adc_shreg_n = {adc_shreg[NBITS-2:0], 1'b0};
                adcdat_n    = adc_shreg[NBITS-2];
                adc_cnt_n   = adc_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_state     <= ADC_IDLE;
            adc_cnt       <= '0;
            adc_shreg     <= '0;
            adcdat        <= 1'b0;
            adc_load_tick <= 1'b0;
        end else begin
            adc_state     <= adc_state_n;
            adc_cnt       <= adc_cnt_n;
            adc_shreg     <= adc_shreg_n;
            adcdat        <= adcdat_n;
            adc_load_tick <= adc_tick_n;
        end
    end

endmodule

// File: tb/tb_codec_serial_slave.sv
// tb/tb_codec_serial_slave.sv - directed self-checking bench for codec_serial_slave
module tb_codec_serial_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b_clk = 1'b0;
    logic        dac_lr_clk = 1'b0;
    logic        adc_lr_clk = 1'b0;
    logic        dacdat = 1'b0;
    logic [31:0] adc_data_in = '0;
    logic        adcdat;
    logic        adc_load_tick;
    logic [31:0] dac_data_out;
    logic        dac_valid;
    logic        frame_err;

    int  tests = 0;
    int  fails = 0;
    int  valid_cnt = 0;
    int  err_cnt = 0;
    int  tick_cnt = 0;
    int  v0, e0, t0;
    time valid_t = 0;
    time rise_t = 0;
    logic [31:0] adc_cap = '0;

    codec_serial_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(rst),
        .b_clk(b_clk),
        .dac_lr_clk(dac_lr_clk),
        .adc_lr_clk(adc_lr_clk),
        .dacdat(dacdat),
        .adcdat(adcdat),
        .adc_data_in(adc_data_in),
        .adc_load_tick(adc_load_tick),
        .dac_data_out(dac_data_out),
        .dac_valid(dac_valid),
        .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (dac_valid) begin
                valid_cnt = valid_cnt + 1;
                valid_t   = $time;
            end
            if (frame_err)     err_cnt  = err_cnt + 1;
            if (adc_load_tick) tick_cnt = tick_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_cycle(input logic lr, input logic dat);
        b_clk      = 1'b0;
        dac_lr_clk = lr;
        adc_lr_clk = lr;
        dacdat     = dat;
        #160;
        b_clk   = 1'b1;
        rise_t  = $time;
        adc_cap = {adc_cap[30:0], adcdat};
        #160;
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int last);
        for (int i = first; i <= last; i++)
            bit_cycle(i < 16, w[31-i]);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        e0 = err_cnt;
        t0 = tick_cnt;
    endtask

    initial begin
        #100;
        @(posedge clk);
        #5 rst = 1'b0;

        // reset state and quiet period
        #2000;
        check("rst_adcdat", adcdat, 0);
        check("rst_dac_data", dac_data_out, 0);
        check("rst_valid_cnt", valid_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_tick_cnt", tick_cnt, 0);

        // single frame, DAC receive and ADC loop-back
        adc_data_in = 32'h12345678;
        bit_cycle(1'b0, 1'b0);
        snap();
        send_bits(32'hAACCAACC, 0, 31);
        check("f1_dac_data", dac_data_out, 32'hAACCAACC);
        check("f1_valid_once", valid_cnt - v0, 1);
        check("f1_latency_ok", ((valid_t - rise_t) <= 80), 1);
        check("f1_adc_word", adc_cap, 32'h12345678);
        check("f1_tick_once", tick_cnt - t0, 1);
        bit_cycle(1'b0, 1'b0);
        check("f1_adcdat_idle", adcdat, 0);
        check("f1_no_err", err_cnt - e0, 0);

        // short frame then full frame
        snap();
        send_bits(32'hFFFFF000, 0, 19);
        send_bits(32'h0000FFFF, 0, 3);
        check("short_err_once", err_cnt - e0, 1);
        check("short_data_kept", dac_data_out, 32'hAACCAACC);
        check("short_no_valid", valid_cnt - v0, 0);
        send_bits(32'h0000FFFF, 4, 31);
        bit_cycle(1'b0, 1'b0);
        check("after_short_data", dac_data_out, 32'h0000FFFF);
        check("after_short_valid", valid_cnt - v0, 1);
        check("after_short_err", err_cnt - e0, 1);

        // back-to-back frames
        snap();
        adc_data_in = 32'hCAFEF00D;
        send_bits(32'h80000001, 0, 0);
        adc_data_in = 32'h0F0F1234;
        send_bits(32'h80000001, 1, 31);
        check("b2b_dac_1", dac_data_out, 32'h80000001);
        check("b2b_adc_1", adc_cap, 32'hCAFEF00D);
        send_bits(32'h7FFFFFFE, 0, 31);
        check("b2b_dac_2", dac_data_out, 32'h7FFFFFFE);
        check("b2b_adc_2", adc_cap, 32'h0F0F1234);
        bit_cycle(1'b0, 1'b0);
        check("b2b_valid_two", valid_cnt - v0, 2);
        check("b2b_tick_two", tick_cnt - t0, 2);
        check("b2b_no_err", err_cnt - e0, 0);

        // reset mid-frame
        adc_data_in = 32'hFFFFFFFF;
        send_bits(32'hDEADBEEF, 0, 9);
        snap();
        rst = 1'b1;
        #1;
        check("midrst_dac_data", dac_data_out, 0);
        check("midrst_adcdat", adcdat, 0);
        check("midrst_valid", dac_valid, 0);
        b_clk      = 1'b0;
        dac_lr_clk = 1'b0;
        adc_lr_clk = 1'b0;
        dacdat     = 1'b0;
        #39;
        rst = 1'b0;
        bit_cycle(1'b0, 1'b0);
        bit_cycle(1'b0, 1'b0);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_adcdat_idle", adcdat, 0);
        adc_data_in = 32'h2468ACE0;
        send_bits(32'h13579BDF, 0, 31);
        check("post_rst_dac", dac_data_out, 32'h13579BDF);
        check("post_rst_adc", adc_cap, 32'h2468ACE0);
        bit_cycle(1'b0, 1'b0);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_err", err_cnt - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/codec_serial_slave.md
Name: codec_serial_slave

Overview:
- Codec-side end of the WM8731 digital audio interface: the counterpart to the master controller.
- Slave only. It does not generate clocks; it samples the master's b_clk, dac_lr_clk and adc_lr_clk with the system clock.
- Deserialises dacdat into parallel stereo words and serialises a parallel ADC word onto adcdat.
- Used as a synthesizable codec model for loop-back checking of the controller, and as the audio port of the FPGA-side codec emulator.

Parameters:
- DATA_W, 16, bits per channel; frame = 2*DATA_W bits, left channel first.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (min 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- b_clk  in  1  serial bit clock from master (asynchronous to clk).
- dac_lr_clk  in  1  DAC frame clock; high = left, low = right.
- adc_lr_clk  in  1  ADC frame clock; high = left, low = right.
- dacdat  in  1  serial DAC data from master.
- adcdat  out  1  serial ADC data to master.
- adc_data_in  in  2*DATA_W  next ADC frame, {left, right}, MSB first.
- adc_load_tick  out  1  one-clk pulse: adc_data_in captured; source may update.
- dac_data_out  out  2*DATA_W  last complete DAC frame, {left, right}.
- dac_valid  out  1  one-clk pulse: dac_data_out updated.
- frame_err  out  1  one-clk pulse: DAC frame aborted (short frame).

Behaviour:
- Format: left-justified, MSB first.
  - Master changes lr clocks and data on b_clk falling edge; receiver samples on b_clk rising edge.
  - First bit of a frame is the bit sampled on the first b_clk rise after the lr clock rises.
- Input conditioning:
  - b_clk, dac_lr_clk, adc_lr_clk and dacdat each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - dacdat shares the same stage count as b_clk, so sampled data stays aligned with the detected edge.
- Timing constraint: b_clk high and low times must each be at least SYNC_STAGES+2 clk periods. Slower b_clk is supported down to DC.
- Reset values:
  - adcdat=0, dac_data_out=0, dac_valid=0, adc_load_tick=0, frame_err=0.
  - Shift registers and counters cleared; both FSMs in IDLE.
- DAC receive FSM:
  - IDLE -> SHIFT on synchronised dac_lr_clk rising edge; bit counter cleared.
  - SHIFT: on each synced b_clk rising edge, shift dacdat into the LSB and increment the counter.
  - When counter reaches 2*DATA_W: copy the shift register to dac_data_out, pulse dac_valid on the next clk, go to DONE.
  - DONE: further b_clk edges are ignored (over-length frame). Next dac_lr_clk rise -> SHIFT.
  - dac_lr_clk rise while in SHIFT with counter < 2*DATA_W: pulse frame_err, leave dac_data_out unchanged, restart SHIFT with counter cleared.
  - b_clk rise and lr rise detected in the same clk: frame start wins; that bit is the new frame's MSB.
- ADC transmit FSM:
  - IDLE -> SEND on synced adc_lr_clk rising edge. In that same clk:
    - load adc_data_in into the shift register;
    - drive its MSB on adcdat;
    - pulse adc_load_tick.
  - SEND: on each synced b_clk falling edge, shift left and drive the next bit. After 2*DATA_W-1 shifts, the LSB has been presented.
  - On the following b_clk fall, adcdat=0 and the FSM goes to IDLE.
  - adc_lr_clk rise during SEND: reload immediately and pulse adc_load_tick (frame restart; no error flag).
  - adcdat is registered; latency from lr rise at the pin to a valid MSB is SYNC_STAGES+2 clk.
- Both FSMs are independent. DAC and ADC frames may overlap or share identical lr clocks.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded with no dac_valid or frame_err.

Decomposition:
- Shared package codec_pkg:
  - FSM state encodings (IDLE/SHIFT/DONE, IDLE/SEND);
  - DATA_W default;
  - frame-length constant FRAME_BITS = 2*DATA_W.
- One natural sub-module: codec_sync_edge. It is a parameterised SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated for b_clk and for each lr clock. dacdat uses the same module with its edge outputs unused.

Test Plan:
- Common setup: clk 50 MHz, b_clk period 320 ns, DATA_W=16.
- Reset release with all inputs low -> all outputs 0 and no pulses for 2 µs.
- Master sends DAC frame 0xAACCAACC -> dac_data_out=0xAACCAACC with exactly one dac_valid pulse, no more than 4 clk after the 32nd b_clk rise.
- adc_data_in=0x12345678, adc_lr_clk rises -> one adc_load_tick pulse. Bits sampled on b_clk rises read 0x12345678 MSB first; adcdat=0 after bit 32.
- Short DAC frame: 20 bits, then dac_lr_clk rises -> one frame_err pulse, dac_data_out keeps its prior value, no dac_valid. The following full frame 0x0000FFFF is received correctly.
- Back-to-back frames 0x80000001 then 0x7FFFFFFE with no idle b_clk cycles -> two dac_valid pulses with the correct values. The adcdat loop-back word equals adc_data_in both times.
- Reset pulsed at bit 10 of a DAC and ADC frame -> outputs 0 immediately, no dac_valid or frame_err. The next complete frame is received normally.
